coord_framebuffer_sink: RTL and testbench

Consumer end of the coordinate-stream interface driven by the generated drawing generators (circle/line/rectangle), which emit signed `(_out0, _out1)` pixel pairs and a level `_done`. This block accepts that stream through a valid/ready handshake and buffers it in a small FIFO. It clips each pixel against a fixed-size 1-bit framebuffer and plots the in-bounds ones. A registered read port lets a display path or testbench read back the image.

---
 rtl/draw_stream_pkg.sv | 16 +
 rtl/coord_fifo.sv | 56 +++++
 rtl/coord_framebuffer_sink.sv | 132 +++++++++++++
 tb/tb_coord_framebuffer_sink.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_stream_pkg.sv
// Types and constants shared by the coordinate generators and the framebuffer sink.
package draw_stream_pkg;

  localparam int COORD_W_DEFAULT = 32;

  typedef logic signed [COORD_W_DEFAULT-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sink_state_t;

endpackage

// File: rtl/coord_fifo.sv
// Small synchronous FIFO for packed {x, y} coordinate pairs with a synchronous flush.
module coord_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              _clock,
  input  logic              _reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge _clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/coord_framebuffer_sink.sv
// Consumes a signed coordinate stream, clips it to a 1-bit framebuffer and plots it.
module coord_framebuffer_sink
  import draw_stream_pkg::*;
#(
  parameter int FB_W       = 16,
  parameter int FB_H       = 16,
  parameter int COORD_W    = COORD_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                       _clock,
  input  logic                       _reset_n,
  input  logic                       _start,
  input  logic signed [COORD_W-1:0]  _in0,
  input  logic signed [COORD_W-1:0]  _in1,
  input  logic                       _in_valid,
  output logic                       _in_ready,
  input  logic                       _in_done,
  input  logic [$clog2(FB_W)-1:0]    rd_x,
  input  logic [$clog2(FB_H)-1:0]    rd_y,
  output logic                       rd_data,
  output logic [CNT_W-1:0]           plot_count,
  output logic [CNT_W-1:0]           set_count,
  output logic [CNT_W-1:0]           clip_count,
  output logic                       _done
);

  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 2 * COORD_W;

  sink_state_t              state;
  logic [FB_W-1:0]          fb [FB_H];
  logic [YW-1:0]            clr_row;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [AW:0]              fifo_count;
  logic [DW-1:0]            head;
  logic signed [COORD_W-1:0] head_x;
  logic signed [COORD_W-1:0] head_y;
  logic                     in_bounds;
  logic                     old_bit;

  assign pop       = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
  assign _in_ready = (state == RUN) && (!fifo_full || pop);
  assign push      = _in_valid && _in_ready;
  assign _done     = (state == DONE);

  assign head_x = head[DW-1:COORD_W];
  assign head_y = head[COORD_W-1:0];

  // Sign bit rejects negatives; the remaining magnitude is compared against the bound.
  assign in_bounds = !head_x[COORD_W-1] && (head_x[COORD_W-2:0] < (COORD_W-1)'(FB_W)) &&
                     !head_y[COORD_W-1] && (head_y[COORD_W-2:0] < (COORD_W-1)'(FB_H));
  assign old_bit   = fb[head_y[YW-1:0]][head_x[XW-1:0]];

  coord_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DW)
  ) u_fifo (
    ._clock   (_clock),
    ._reset_n (_reset_n),
    .flush    (_start),
    .push     (push),
    .pop      (pop),
    .wr_data  ({_in0, _in1}),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state   <= IDLE;
      clr_row <= '0;
    end else if (_start) begin
      state   <= CLEAR;
      clr_row <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_row <= clr_row + 1'b1;
          if (clr_row == YW'(FB_H - 1)) state <= RUN;
        end
        RUN:     if (_in_done) state <= DRAIN;
        DRAIN:   if (fifo_count == '0) state <= DONE;
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      for (int r = 0; r < FB_H; r++) fb[r] <= '0;
    end else if (!_start) begin
      if (state == CLEAR)
        fb[clr_row] <= '0;
      else if (pop && in_bounds)
        fb[head_y[YW-1:0]][head_x[XW-1:0]] <= 1'b1;
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      plot_count <= '0;
      set_count  <= '0;
      clip_count <= '0;
    end else if (_start) begin
      plot_count <= '0;
      set_count  <= '0;
      clip_count <= '0;
    end else if (pop) begin
      if (in_bounds) begin
        if (plot_count != '1) plot_count <= plot_count + 1'b1;
        if (!old_bit && (set_count != '1)) set_count <= set_count + 1'b1;
      end else if (clip_count != '1) begin
        clip_count <= clip_count + 1'b1;
      end
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) rd_data <= 1'b0;
    else           rd_data <= fb[rd_y][rd_x];
  end

endmodule

// File: tb/tb_coord_framebuffer_sink.sv
// Directed and randomized checks of coord_framebuffer_sink against a pixel-array model.
module tb_coord_framebuffer_sink;
  import draw_stream_pkg::*;

  localparam int FB_W = 16;
  localparam int FB_H = 16;

  logic        _clock = 1'b0;
  logic        _reset_n = 1'b0;
  logic        _start = 1'b0;
  coord_t      _in0 = '0;
  coord_t      _in1 = '0;
  logic        _in_valid = 1'b0;
  logic        _in_ready;
  logic        _in_done = 1'b0;
  logic [3:0]  rd_x = '0;
  logic [3:0]  rd_y = '0;
  logic        rd_data;
  logic [15:0] plot_count;
  logic [15:0] set_count;
  logic [15:0] clip_count;
  logic        _done;

  int compared = 0;
  int mismatched = 0;

  bit modelFb [FB_H][FB_W];
  int modelPlot, modelSet, modelClip;

  coord_framebuffer_sink dut (
    ._clock     (_clock),
    ._reset_n   (_reset_n),
    ._start     (_start),
    ._in0       (_in0),
    ._in1       (_in1),
    ._in_valid  (_in_valid),
    ._in_ready  (_in_ready),
    ._in_done   (_in_done),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .plot_count (plot_count),
    .set_count  (set_count),
    .clip_count (clip_count),
    ._done      (_done)
  );

  always #5 _clock = ~_clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++) modelFb[y][x] = 1'b0;
    modelPlot = 0; modelSet = 0; modelClip = 0;
  endtask

  task automatic modelAccept(input int x, input int y);
    if (x >= 0 && x < FB_W && y >= 0 && y < FB_H) begin
      modelPlot++;
      if (!modelFb[y][x]) modelSet++;
      modelFb[y][x] = 1'b1;
    end else begin
      modelClip++;
    end
  endtask

  task automatic pulseStart();
    _start = 1'b1;
    @(negedge _clock);
    _start = 1'b0;
    modelClear();
  endtask

  task automatic applyStimulus(input int x, input int y, output int waitCycles);
    waitCycles = 0;
    _in0 = x; _in1 = y; _in_valid = 1'b1;
    while (!_in_ready && waitCycles < 200) begin
      @(negedge _clock);
      waitCycles++;
    end
    if (waitCycles >= 200) begin
      checkOutput("accept_timeout", 32'(waitCycles), 32'd0);
    end else begin
      modelAccept(x, y);
      @(negedge _clock);
    end
    _in_valid = 1'b0;
    _in0 = 'x; _in1 = 'x;
  endtask

  task automatic finishStream();
    int n = 0;
    while (!_in_ready && n < 100) begin @(negedge _clock); n++; end
    _in_done = 1'b1;
    @(negedge _clock);
    _in_done = 1'b0;
    n = 0;
    while (!_done && n < FB_H + 4) begin @(negedge _clock); n++; end
    checkOutput("done_rise", {31'd0, _done}, 32'd1);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_plot"}, 32'(plot_count), 32'(modelPlot));
    checkOutput({tag, "_set"},  32'(set_count),  32'(modelSet));
    checkOutput({tag, "_clip"}, 32'(clip_count), 32'(modelClip));
  endtask

  task automatic readPixel(input int x, input int y, input string tag, input bit expected);
    rd_x = 4'(x); rd_y = 4'(y);
    @(negedge _clock);
    checkOutput(tag, {31'd0, rd_data}, {31'd0, expected});
  endtask

  task automatic scanFb(input string tag);
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++)
        readPixel(x, y, tag, modelFb[y][x]);
  endtask

  initial begin
    int w;
    int cx, cy, d;
    int px[8], py[8];
    int pending;

    $display("[TB] reset");
    modelClear();
    repeat (3) @(negedge _clock);
    checkOutput("rst_ready", {31'd0, _in_ready}, 32'd0);
    checkOutput("rst_done",  {31'd0, _done},     32'd0);
    checkOutput("rst_rd",    {31'd0, rd_data},   32'd0);
    checkCounters("rst");
    _reset_n = 1'b1;
    @(negedge _clock);
    checkOutput("idle_ready", {31'd0, _in_ready}, 32'd0);

    $display("[TB] test 1: single pair");
    pulseStart();
    checkOutput("start_done_low", {31'd0, _done}, 32'd0);
    applyStimulus(3, 5, w);
    finishStream();
    readPixel(3, 5, "t1_pix", 1'b1);
    scanFb("t1_scan");
    checkCounters("t1");

    $display("[TB] test 2: clipping");
    pulseStart();
    applyStimulus(-1, 0, w);
    applyStimulus(16, 2, w);
    applyStimulus(4, -7, w);
    applyStimulus(0, 16, w);
    applyStimulus(15, 15, w);
    finishStream();
    checkOutput("t2_clip_const", 32'(clip_count), 32'd4);
    scanFb("t2_scan");
    checkCounters("t2");

    $display("[TB] test 3: midpoint circle r=3 at (8,8)");
    pulseStart();
    cx = 0; cy = 3; d = 1 - 3;
    while (cx <= cy) begin
      px = '{cx, cy, -cx, -cy, cx, cy, -cx, -cy};
      py = '{cy, cx, cy, cx, -cy, -cx, -cy, -cx};
      for (int k = 0; k < 8; k++) applyStimulus(8 + px[k], 8 + py[k], w);
      cx++;
      if (d < 0) d += 2 * cx + 1;
      else begin cy--; d += 2 * (cx - cy) + 1; end
    end
    finishStream();
    checkOutput("t3_set_const", 32'(set_count), 32'd16);
    readPixel(8, 11, "t3_8_11", 1'b1);
    readPixel(11, 8, "t3_11_8", 1'b1);
    readPixel(10, 10, "t3_10_10", 1'b1);
    readPixel(6, 6, "t3_6_6", 1'b1);
    readPixel(8, 8, "t3_centre", 1'b0);
    scanFb("t3_scan");
    checkCounters("t3");

    $display("[TB] test 4: 12 back-to-back random pairs");
    pulseStart();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(int'($urandom_range(19, 0)) - 4, int'($urandom_range(19, 0)) - 4, w);
      if (i > 0) checkOutput("t4_no_stall", 32'(w), 32'd0);
    end
    finishStream();
    checkOutput("t4_total", 32'(plot_count) + 32'(clip_count), 32'd12);
    scanFb("t4_scan");
    checkCounters("t4");

    $display("[TB] test 5: start pulse mid-run");
    pulseStart();
    for (int i = 0; i < 3; i++)
      applyStimulus(int'($urandom_range(FB_W - 1, 0)), int'($urandom_range(FB_H - 1, 0)), w);
    _in0 = 5; _in1 = 5; _in_valid = 1'b1;
    pulseStart();
    _in_valid = 1'b0;
    checkCounters("t5_abort");
    repeat (FB_H + 2) @(negedge _clock);
    scanFb("t5_cleared");
    pending = int'($urandom_range(8, 4));
    for (int i = 0; i < pending; i++)
      applyStimulus(int'($urandom_range(FB_W + 1, 0)) - 1, int'($urandom_range(FB_H + 1, 0)) - 1, w);
    finishStream();
    scanFb("t5_scan");
    checkCounters("t5");

    $display("[TB] test 6: async reset mid-drain");
    pulseStart();
    for (int i = 0; i < 4; i++) applyStimulus(i, i + 1, w);
    _in_done = 1'b1;
    @(posedge _clock);
    #1;
    _in_done = 1'b0;
    _reset_n = 1'b0;
    #1;
    modelClear();
    checkOutput("t6_ready", {31'd0, _in_ready}, 32'd0);
    checkOutput("t6_done",  {31'd0, _done},     32'd0);
    checkOutput("t6_rd",    {31'd0, rd_data},   32'd0);
    checkCounters("t6");
    @(negedge _clock);
    _reset_n = 1'b1;
    @(negedge _clock);
    checkOutput("t6_idle_ready", {31'd0, _in_ready}, 32'd0);
    scanFb("t6_scan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
